// File: rtl/md_sched.sv
// md_sched: HI/LO multiply/divide scheduler with fixed-latency commit.
// Optional MD_SCHED_CANCEL_EN: cancel suppresses a same-cycle launch.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [4:0]  cnt, cnt_n;
  logic [31:0] hi_q, hi_n, lo_q, lo_n;
  logic [31:0] pend_hi, pend_hi_n;
  logic [31:0] pend_lo, pend_lo_n;
  logic        pend_ok, pend_ok_n;
  logic        done_q, done_n;
  logic        go;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        divisor;
  logic [31:0]        quot_s, rem_s;
  logic [31:0]        quot_u, rem_u;
  logic               div_zero, div_ovf;
  logic               is_mul, is_div;

`ifdef MD_SCHED_CANCEL_EN
  assign go = start & ~cancel;
`else
  logic unused_cancel;
  assign unused_cancel = cancel;
  assign go = start;
`endif

  assign state = (cnt != 5'd0) ? RUN : IDLE;
  assign is_mul = (op == 3'd0) || (op == 3'd1);
  assign is_div = (op == 3'd2) || (op == 3'd3);

  assign prod_s = $signed({{32{src_a[31]}}, src_a})
                * $signed({{32{src_b[31]}}, src_b});
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

  // Dummy divisor keeps the dividers well-defined on /0 and MIN/-1
  assign div_zero = (src_b == 32'd0);
  assign div_ovf  = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
  assign divisor  = (div_zero || div_ovf) ? 32'd1 : src_b;
  assign quot_s = div_ovf ? 32'h8000_0000
                : 32'($signed(src_a) / $signed(divisor));
  assign rem_s  = div_ovf ? 32'd0
                : 32'($signed(src_a) % $signed(divisor));
  assign quot_u = src_a / divisor;
  assign rem_u  = src_a % divisor;

  always_comb begin
    cnt_n     = cnt;
    hi_n      = hi_q;
    lo_n      = lo_q;
    pend_hi_n = pend_hi;
    pend_lo_n = pend_lo;
    pend_ok_n = pend_ok;
    done_n    = 1'b0;
    if (state == RUN) begin
      if (cnt == 5'd1) begin
        cnt_n  = 5'd0;
        done_n = 1'b1;
        if (pend_ok) begin
          hi_n = pend_hi;
          lo_n = pend_lo;
        end
      end else begin
        cnt_n = cnt - 5'd1;
      end
    end else if (go) begin
      unique case (1'b1)
        is_mul: begin
          if (op[0]) {pend_hi_n, pend_lo_n} = prod_u;
          else       {pend_hi_n, pend_lo_n} = prod_s;
          pend_ok_n = 1'b1;
          cnt_n     = 5'(MULT_CYCLES);
        end
        is_div: begin
          pend_hi_n = op[0] ? rem_u  : rem_s;
          pend_lo_n = op[0] ? quot_u : quot_s;
          pend_ok_n = ~div_zero;
          cnt_n     = 5'(DIV_CYCLES);
        end
        (op == 3'd4): hi_n = src_a;
        (op == 3'd5): lo_n = src_a;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_ok <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      hi_q    <= hi_n;
      lo_q    <= lo_n;
      pend_hi <= pend_hi_n;
      pend_lo <= pend_lo_n;
      pend_ok <= pend_ok_n;
      done_q  <= done_n;
    end
  end

  assign busy = (state == RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed checks of md_sched latency, results and control.
// Honours MD_SCHED_CANCEL_EN for the cancel scenario.
module tb_md_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        cancel = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  md_sched dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .cancel(cancel),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic do_launch(input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic c);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b; cancel = c;
    @(posedge clk);
    #1;
    start = 1'b0; cancel = 1'b0;
  endtask

  // Counts busy cycles after a launch; returns done at first idle sample
  task automatic wait_idle(output int n, output logic dn);
    n = 0;
    dn = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin
        dn = done;
        break;
      end
      n++;
    end
  endtask

  task automatic test_reset;
    #1;
    n_cmp += 4;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", done); end
    if (hi !== 32'd0) begin n_bad++; $display("FAIL rst_hi got %h want 0", hi); end
    if (lo !== 32'd0) begin n_bad++; $display("FAIL rst_lo got %h want 0", lo); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mult;
    int n; logic dn;
    do_launch(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (lo !== 32'd0) begin n_bad++; $display("FAIL mult_early_lo got %h want 0", lo); end
    wait_idle(n, dn);
    n++;
    n_cmp += 5;
    if (n !== 5) begin n_bad++; $display("FAIL mult_busy got %0d want 5", n); end
    if (dn !== 1'b1) begin n_bad++; $display("FAIL mult_done got %b want 1", dn); end
    if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    if (lo !== 32'hFFFF_FFEB) begin n_bad++; $display("FAIL mult_lo got %h want ffffffeb", lo); end
    @(negedge clk);
    if (done !== 1'b0) begin n_bad++; $display("FAIL mult_done_pulse got %b want 0", done); end
  endtask

  task automatic test_multu;
    int n; logic dn;
    do_launch(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_idle(n, dn);
    n_cmp += 3;
    if (n !== 5) begin n_bad++; $display("FAIL multu_busy got %0d want 5", n); end
    if (hi !== 32'd1) begin n_bad++; $display("FAIL multu_hi got %h want 1", hi); end
    if (lo !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_lo got %h want fffffffe", lo); end
  endtask

  task automatic test_div;
    int n; logic dn;
    do_launch(3'd3, 32'd100, 32'd7, 1'b0);
    wait_idle(n, dn);
    n_cmp += 4;
    if (n !== 10) begin n_bad++; $display("FAIL divu_busy got %0d want 10", n); end
    if (dn !== 1'b1) begin n_bad++; $display("FAIL divu_done got %b want 1", dn); end
    if (lo !== 32'd14) begin n_bad++; $display("FAIL divu_lo got %h want e", lo); end
    if (hi !== 32'd2) begin n_bad++; $display("FAIL divu_hi got %h want 2", hi); end
    do_launch(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle(n, dn);
    n_cmp += 3;
    if (n !== 10) begin n_bad++; $display("FAIL div_busy got %0d want 10", n); end
    if (lo !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_lo got %h want fffffffd", lo); end
    if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_hi got %h want ffffffff", hi); end
    do_launch(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle(n, dn);
    n_cmp += 2;
    if (lo !== 32'h8000_0000) begin n_bad++; $display("FAIL div_ovf_lo got %h want 80000000", lo); end
    if (hi !== 32'd0) begin n_bad++; $display("FAIL div_ovf_hi got %h want 0", hi); end
  endtask

  task automatic test_mthi_mtlo_divzero;
    int n; logic dn;
    do_launch(3'd4, 32'h1234, 32'd0, 1'b0);
    n_cmp += 2;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL mthi_busy got %b want 0", busy); end
    if (hi !== 32'h1234) begin n_bad++; $display("FAIL mthi_hi got %h want 1234", hi); end
    do_launch(3'd5, 32'h5678, 32'd0, 1'b0);
    @(negedge clk);
    n_cmp += 3;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL mtlo_busy got %b want 0", busy); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL mtlo_done got %b want 0", done); end
    if (lo !== 32'h5678) begin n_bad++; $display("FAIL mtlo_lo got %h want 5678", lo); end
    do_launch(3'd2, 32'd5, 32'd0, 1'b0);
    wait_idle(n, dn);
    n_cmp += 4;
    if (n !== 10) begin n_bad++; $display("FAIL div0_busy got %0d want 10", n); end
    if (dn !== 1'b1) begin n_bad++; $display("FAIL div0_done got %b want 1", dn); end
    if (hi !== 32'h1234) begin n_bad++; $display("FAIL div0_hi got %h want 1234", hi); end
    if (lo !== 32'h5678) begin n_bad++; $display("FAIL div0_lo got %h want 5678", lo); end
  endtask

  task automatic test_reserved;
    do_launch(3'd6, 32'hDEAD, 32'hBEEF, 1'b0);
    @(negedge clk);
    n_cmp += 3;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rsvd_busy got %b want 0", busy); end
    if (hi !== 32'h1234) begin n_bad++; $display("FAIL rsvd_hi got %h want 1234", hi); end
    if (lo !== 32'h5678) begin n_bad++; $display("FAIL rsvd_lo got %h want 5678", lo); end
  endtask

  task automatic test_cancel;
    int n; logic dn;
    do_launch(3'd0, 32'd3, 32'd4, 1'b1);
    wait_idle(n, dn);
`ifdef MD_SCHED_CANCEL_EN
    n_cmp += 3;
    if (n !== 0) begin n_bad++; $display("FAIL cancel_busy got %0d want 0", n); end
    if (hi !== 32'h1234) begin n_bad++; $display("FAIL cancel_hi got %h want 1234", hi); end
    if (lo !== 32'h5678) begin n_bad++; $display("FAIL cancel_lo got %h want 5678", lo); end
    do_launch(3'd4, 32'h9999, 32'd0, 1'b1);
    n_cmp++;
    if (hi !== 32'h1234) begin n_bad++; $display("FAIL cancel_mthi got %h want 1234", hi); end
`else
    n_cmp += 3;
    if (n !== 5) begin n_bad++; $display("FAIL cancel_busy got %0d want 5", n); end
    if (hi !== 32'd0) begin n_bad++; $display("FAIL cancel_hi got %h want 0", hi); end
    if (lo !== 32'd12) begin n_bad++; $display("FAIL cancel_lo got %h want c", lo); end
    do_launch(3'd4, 32'h9999, 32'd0, 1'b1);
    n_cmp++;
    if (hi !== 32'h9999) begin n_bad++; $display("FAIL cancel_mthi got %h want 9999", hi); end
`endif
  endtask

  task automatic test_start_during_run;
    int n; logic dn; int b;
    do_launch(3'd0, 32'h0001_0000, 32'h0001_0000, 1'b0);
    b = 0;
    repeat (2) begin
      @(negedge clk);
      if (busy) b++;
    end
    start = 1'b1; op = 3'd5; src_a = 32'hAAAA;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle(n, dn);
    n_cmp += 5;
    if (b + n !== 5) begin n_bad++; $display("FAIL run_ign_busy got %0d want 5", b + n); end
    if (dn !== 1'b1) begin n_bad++; $display("FAIL run_ign_done got %b want 1", dn); end
    if (hi !== 32'd1) begin n_bad++; $display("FAIL run_ign_hi got %h want 1", hi); end
    if (lo !== 32'd0) begin n_bad++; $display("FAIL run_ign_lo got %h want 0", lo); end
    if (lo === 32'hAAAA) begin n_bad++; $display("FAIL run_ign_mtlo got %h want not aaaa", lo); end
  endtask

  task automatic test_back_to_back;
    int b;
    do_launch(3'd1, 32'd3, 32'd5, 1'b0);
    b = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy) b++;
    end
    start = 1'b1; op = 3'd5; src_a = 32'h77;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    n_cmp += 5;
    if (b !== 5) begin n_bad++; $display("FAIL b2b_busy got %0d want 5", b); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got %b want 0", busy); end
    if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_done got %b want 1", done); end
    if (lo !== 32'd15) begin n_bad++; $display("FAIL b2b_lo got %h want f", lo); end
    if (hi !== 32'd0) begin n_bad++; $display("FAIL b2b_hi got %h want 0", hi); end
    do_launch(3'd5, 32'h77, 32'd0, 1'b0);
    n_cmp++;
    if (lo !== 32'h77) begin n_bad++; $display("FAIL b2b_next got %h want 77", lo); end
  endtask

  task automatic test_reset_mid;
    int bad_after;
    do_launch(3'd3, 32'd100, 32'd7, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp += 4;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got %b want 0", busy); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL rmid_done got %b want 0", done); end
    if (hi !== 32'd0) begin n_bad++; $display("FAIL rmid_hi got %h want 0", hi); end
    if (lo !== 32'd0) begin n_bad++; $display("FAIL rmid_lo got %h want 0", lo); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bad_after = 0;
    repeat (15) begin
      @(negedge clk);
      if (busy || done || hi != 32'd0 || lo != 32'd0) bad_after++;
    end
    n_cmp++;
    if (bad_after !== 0) begin n_bad++; $display("FAIL rmid_no_commit got %0d want 0", bad_after); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_mthi_mtlo_divzero();
    test_reserved();
    test_cancel();
    test_start_during_run();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/md_sched.md
# md_sched

Multiply/divide scheduler for the E-stage HI/LO resource. It accepts one operation per launch from the E stage and computes the result at launch. It holds the result in pending registers for a fixed latency, driving `busy` so the control unit stalls dependent instructions, then commits the result to architectural HI/LO. It also sequences mthi/mtlo writes and suppresses launch when an interrupt/exception request lands in the launch cycle.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu; legal 1..31
- `DIV_CYCLES`, default 10: busy cycles for div/divu; legal 1..31

Ports:
- `clk`  in  1: clock, rising edge
- `reset`  in  1: asynchronous, active-high; clears all state
- `start`  in  1: launch request from E stage, sampled at rising edge
- `op`  in  3: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 reserved (no-op)
- `src_a`  in  32: rs operand (forwarded value)
- `src_b`  in  32: rt operand (forwarded value)
- `cancel`  in  1: exception/interrupt request in the launch cycle
- `busy`  out  1: operation in flight
- `done`  out  1: one-cycle pulse in the cycle after commit
- `hi`  out  32: architectural HI
- `lo`  out  32: architectural LO

## Operation
- States: IDLE and RUN. A 5-bit down-counter `cnt` sets the state: RUN iff `cnt != 0`. `busy` = RUN.
- IDLE, `start`, op 0..3, launch not suppressed:
  - compute the 64-bit result combinationally from `src_a`/`src_b` into `pend_hi`/`pend_lo`
  - load `cnt` with MULT_CYCLES or DIV_CYCLES; go to RUN
- mult/multu: {HI,LO} = signed/unsigned 32x32 product, full 64 bits.
- div/divu: LO = quotient, HI = remainder.
  - signed results truncate toward zero; remainder takes the sign of the dividend
  - 0x80000000 / 0xFFFFFFFF (signed): LO = 0x80000000, HI = 0
  - divisor 0: set pending-valid-to-commit = 0; HI/LO stay unchanged at commit; busy still runs DIV_CYCLES and `done` still pulses
- mthi/mtlo in IDLE: write `src_a` to HI/LO at the launch edge. No RUN, no `done`.
- RUN: `cnt` decrements each edge. At the edge where `cnt` == 1, commit the pending values to HI/LO (unless div-by-zero) and set `cnt` = 0. `done` is registered high for the following cycle.
- `start` while RUN: ignored, including mthi/mtlo. The control unit guarantees no such launch (stalls on start|busy in D). The bench checks that state is unaffected.
- Reserved op with `start`: no state change.
- `hi`/`lo` always show architectural values. Pending results are never visible before commit.
- Reset mid-operation: `cnt`, `done`, HI, LO and pending registers clear immediately. No commit occurs.

## Timing
- Reset values: `busy` 0, `done` 0, `hi` 0, `lo` 0.
- Launch sampled at edge T. `busy` is high from T+ for N cycles (N = MULT_CYCLES or DIV_CYCLES) and low after edge T+N.
- New HI/LO are visible from edge T+N. `done` is high for one cycle, from T+N to T+N+1.
- Back-to-back: a launch at edge T+N (the commit edge) is not accepted, because the unit is still RUN at that edge. The earliest next launch is edge T+N+1.
- mthi/mtlo: launched at edge T, visible from T+, zero busy cycles.
- Outputs are registered only. There is no combinational path from inputs to `busy`/`hi`/`lo`/`done`.

## Configuration
- `MD_SCHED_CANCEL_EN` defined: `cancel`=1 in the same cycle as `start` suppresses the launch entirely, for all ops including mthi/mtlo. This matches the pipeline flushing the E-stage instruction on an interrupt. `cancel` during RUN has no effect, because the in-flight op is already architecturally committed.
- Not defined: the `cancel` port is present but ignored; `start` alone launches.

## Test plan
- mult, src_a=0xFFFFFFFD (-3), src_b=7 -> busy for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB; done pulses once.
- divu, 100/7 -> busy for exactly 10 cycles; then LO=14, HI=2. Also div, -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- HI/LO preloaded via mthi 0x1234 and mtlo 0x5678 (no busy); then div x/0 -> busy 10 cycles, done pulses, HI=0x1234 and LO=0x5678 unchanged.
- start+mult with cancel=1 -> with MD_SCHED_CANCEL_EN: busy stays 0, HI/LO unchanged. Without: normal 5-cycle mult.
- start during RUN (mtlo 0xAAAA at cycle 3 of a mult) -> ignored; final HI/LO equal the product and LO≠0xAAAA.
- reset asserted at cycle 4 of a divu -> busy, done, HI and LO all 0 immediately; no later commit after reset deasserts.
